traffic_countdown: RTL and testbench
====================================

# traffic_countdown

Phase timer that sits on the far side of the traffic-light controller's strobe interface. It turns the controller's one-per-phase load strobes (`red_s`, `green_s`, `yellow_s`, `init_s`, `save_s`, `five_time`, `eight_time`) into a down-counting `rest_time` in seconds. The controller polls `rest_time` for zero to advance phases. The block also drives the two-digit BCD display and its blanking.

## Interface
- `TICK_DIV`, 100000000, clk cycles per one-second tick; legal range ≥ 2.
- `RED_T`, 20, seconds loaded on `red_s`.
- `GREEN_T`, 30, seconds loaded on `green_s`.
- `YELLOW_T`, 3, seconds loaded on `yellow_s`.
- `FIVE_T`, 5, seconds loaded on `five_time`.
- `EIGHT_T`, 8, seconds loaded on `eight_time`.
- `clk` in 1, single clock; all state on posedge.
- `rst` in 1, synchronous, active-high reset.
- `red_s`, `green_s`, `yellow_s` in 1 each, level load strobes.
- `init_s`, `save_s`, `five_time`, `eight_time` in 1 each, level load strobes.
- `p_rest_time` in 7, value loaded on `save_s` (resume after online/IMP).
- `pause_r` in 1, freeze countdown and prescaler.
- `dis` in 1, freeze countdown and prescaler, and blank the display.
- `rest_time` out 7, remaining seconds, 0..99.
- `tens` out 4, BCD tens digit of `rest_time`.
- `ones` out 4, BCD ones digit of `rest_time`.
- `tick` out 1, one-cycle pulse on each prescaler wrap.
- `blank` out 1, registered copy of `dis`.

## Operation
- **Prescaler:** `pre` counts 0..`TICK_DIV`-1. `tick`=1 in the cycle after `pre` = `TICK_DIV`-1, and `pre` returns to 0 at that point.
- **Prescaler freeze:** `pre` holds its value while `pause_r` or `dis` is 1, so the sub-second phase is preserved across pauses.
- **Prescaler clear:** any load strobe clears `pre` to 0.
- **Load (level-sensitive):** in every cycle a strobe is high, `rest_time` is loaded and `pre` is cleared. A strobe held for k cycles therefore holds the load value for k cycles.
- **Load priority** when several strobes are high at once, highest first:
  - `init_s` → 0
  - `save_s` → `p_rest_time`, clamped to 99 if larger
  - `red_s` → `RED_T`
  - `green_s` → `GREEN_T`
  - `yellow_s` → `YELLOW_T`
  - `five_time` → `FIVE_T`
  - `eight_time` → `EIGHT_T`
- **Parameter clamp:** all parameter load values are clamped to 99 at elaboration.
- **Decrement:** when `tick` is set internally (`pre` wraps), no strobe is high, `pause_r`=0, `dis`=0 and `rest_time`≠0, then `rest_time` decrements by 1.
- **Floor:** `rest_time` holds at 0 and never wraps to 127.
- **Load vs tick:** a load always wins over a decrement in the same cycle.
- **BCD:** `tens` = `rest_time`/10 and `ones` = `rest_time`%10. They are computed from the registered `rest_time` and registered again, so they lag `rest_time` by one cycle. Digits are always ≤ 9.
- **Reset mid-count:** `rst` overrides all strobes. All state returns to its reset value on the next edge.

## Timing
- **Reset values:** `rest_time`=0, `tens`=0, `ones`=0, `tick`=0, `pre`=0, `blank`=1.
- **Load latency:** strobe sampled at edge N → `rest_time` shows the new value after edge N; `tens`/`ones` follow after edge N+1.
- **First decrement after load:** occurs `TICK_DIV` cycles after the last cycle the strobe was high.
- **Tick:** `tick` is asserted for exactly 1 cycle, coincident with the decrement edge. It is still pulsed when the decrement is suppressed by `rest_time`=0, and it is not pulsed while frozen.
- **Blank:** `blank` lags `dis` by 1 cycle.

## Test plan
- **Red load and countdown.** `TICK_DIV`=4. Reset, then `red_s` high 2 cycles.
  - Required: `rest_time`=20 for both cycles.
  - Required: 19 appears 4 cycles after the strobe drops; then one decrement per 4 cycles down to 0.
  - Required: value stays at 0 with `tick` still pulsing; `tens`/`ones` read 2/0 one cycle after load.
- **Pause preserves phase.** Load `green_s` (30), wait 6 cycles (29, `pre`=2), then `pause_r`=1 for 10 cycles.
  - Required: `rest_time` stays 29 with no `tick` during the pause.
  - Required: the next decrement to 28 occurs 2 cycles after `pause_r` falls.
- **Priority and clamp.**
  - `red_s`, `yellow_s` and `save_s` together with `p_rest_time`=120 → `rest_time`=99, digits 9/9.
  - `init_s` together with `green_s` → 0.
- **Save/resume.** `dis`=1 for 8 cycles, then `save_s` with `p_rest_time`=17.
  - Required: `blank`=1 one cycle after `dis` rises; count frozen throughout.
  - Required: `rest_time`=17 after the strobe; decrement resumes 4 cycles later.
- **Manual sequence.** `five_time` → 5 counts to 0, then `yellow_s` → 3 counts to 0, then `eight_time` → 8.
  - Required: each load lands exactly 1 cycle after its strobe is sampled.
- **Reset mid-operation.** `rst` pulsed while `rest_time`=12 and `red_s` high.
  - Required: all outputs return to reset values, `blank`=1, and the strobe is ignored that cycle.

Source files
------------

// File: rtl/traffic_countdown.sv
`default_nettype none
// ============================================================================
// Module : traffic_countdown
// Brief  : Per-phase seconds countdown with prescaler, BCD digits and blanking.
// Rev    : 1.0  initial release
// ============================================================================
module traffic_countdown #(
    parameter int TICK_DIV = 100000000,
    parameter int RED_T    = 20,
    parameter int GREEN_T  = 30,
    parameter int YELLOW_T = 3,
    parameter int FIVE_T   = 5,
    parameter int EIGHT_T  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_red_s,
    input  logic       i_green_s,
    input  logic       i_yellow_s,
    input  logic       i_init_s,
    input  logic       i_save_s,
    input  logic       i_five_time,
    input  logic       i_eight_time,
    input  logic [6:0] i_p_rest_time,
    input  logic       i_pause_r,
    input  logic       i_dis,
    output logic [6:0] o_rest_time,
    output logic [3:0] o_tens,
    output logic [3:0] o_ones,
    output logic       o_tick,
    output logic       o_blank
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] c_PRE_MAX = PW'(TICK_DIV - 1);

    localparam logic [6:0] c_RED    = (RED_T    > 99) ? 7'd99 : 7'(RED_T);
    localparam logic [6:0] c_GREEN  = (GREEN_T  > 99) ? 7'd99 : 7'(GREEN_T);
    localparam logic [6:0] c_YELLOW = (YELLOW_T > 99) ? 7'd99 : 7'(YELLOW_T);
    localparam logic [6:0] c_FIVE   = (FIVE_T   > 99) ? 7'd99 : 7'(FIVE_T);
    localparam logic [6:0] c_EIGHT  = (EIGHT_T  > 99) ? 7'd99 : 7'(EIGHT_T);

    logic [PW-1:0] r_pre;
    logic [6:0]    r_rest;
    logic [3:0]    r_tens;
    logic [3:0]    r_ones;
    logic          r_tick;
    logic          r_blank;

    logic          w_load;
    logic [6:0]    w_load_val;
    logic          w_frozen;
    logic          w_wrap;
    logic [3:0]    w_tens;
    logic [6:0]    w_tens_x10;
    logic [3:0]    w_ones;

    always_comb begin
        w_load     = 1'b1;
        w_load_val = 7'd0;
        if (i_init_s)          w_load_val = 7'd0;
        else if (i_save_s)     w_load_val = (i_p_rest_time > 7'd99) ? 7'd99 : i_p_rest_time;
        else if (i_red_s)      w_load_val = c_RED;
        else if (i_green_s)    w_load_val = c_GREEN;
        else if (i_yellow_s)   w_load_val = c_YELLOW;
        else if (i_five_time)  w_load_val = c_FIVE;
        else if (i_eight_time) w_load_val = c_EIGHT;
        else                   w_load     = 1'b0;
    end

    assign w_frozen = i_pause_r | i_dis;
    assign w_wrap   = !w_load && !w_frozen && (r_pre == c_PRE_MAX);

    // Digit split by comparison ladder; r_rest never exceeds 99.
    always_comb begin
        w_tens = 4'd0;
        for (int k = 1; k < 10; k++) begin
            if (r_rest >= 7'(10 * k)) w_tens = 4'(k);
        end
    end

    assign w_tens_x10 = 7'd10 * {3'b000, w_tens};
    assign w_ones     = 4'(r_rest - w_tens_x10);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre   <= '0;
            r_rest  <= 7'd0;
            r_tens  <= 4'd0;
            r_ones  <= 4'd0;
            r_tick  <= 1'b0;
            r_blank <= 1'b1;
        end else begin
            r_blank <= i_dis;
            r_tens  <= w_tens;
            r_ones  <= w_ones;
            r_tick  <= w_wrap;
            if (w_load) begin
                r_rest <= w_load_val;
                r_pre  <= '0;
            end else if (!w_frozen) begin
                if (w_wrap) begin
                    r_pre <= '0;
                    if (r_rest != 7'd0) r_rest <= r_rest - 7'd1;
                end else begin
                    r_pre <= r_pre + 1'b1;
                end
            end
        end
    end

    assign o_rest_time = r_rest;
    assign o_tens      = r_tens;
    assign o_ones      = r_ones;
    assign o_tick      = r_tick;
    assign o_blank     = r_blank;

endmodule
`default_nettype wire

// File: tb/tb_traffic_countdown.sv
`default_nettype none
// ============================================================================
// Module : tb_traffic_countdown
// Brief  : Directed bench for traffic_countdown with an elapsed-time model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_traffic_countdown;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       red_s = 0, green_s = 0, yellow_s = 0, init_s = 0, save_s = 0;
    logic       five_time = 0, eight_time = 0, pause_r = 0, dis = 0;
    logic [6:0] p_rest_time = 7'd0;
    logic [6:0] rest_time;
    logic [3:0] tens, ones;
    logic       tick, blank;

    int total = 0;
    int bad   = 0;

    traffic_countdown #(.TICK_DIV(TD)) dut (
        .clk(clk), .rst(rst),
        .i_red_s(red_s), .i_green_s(green_s), .i_yellow_s(yellow_s),
        .i_init_s(init_s), .i_save_s(save_s),
        .i_five_time(five_time), .i_eight_time(eight_time),
        .i_p_rest_time(p_rest_time), .i_pause_r(pause_r), .i_dis(dis),
        .o_rest_time(rest_time), .o_tens(tens), .o_ones(ones),
        .o_tick(tick), .o_blank(blank)
    );

    always #5 clk = ~clk;

    // Model: remaining seconds plus count of unfrozen cycles since the last
    // load or second boundary; a second elapses after TD such cycles.
    int m_rest = 0, m_el = 0, m_tens = 0, m_ones = 0;
    bit m_tick = 0, m_blank = 1, m_valid = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_rest = 0; m_el = 0; m_tens = 0; m_ones = 0;
            m_tick = 0; m_blank = 1; m_valid = 1;
        end else begin
            m_tens  = m_rest / 10;
            m_ones  = m_rest % 10;
            m_blank = dis;
            m_tick  = 0;
            if (init_s || save_s || red_s || green_s || yellow_s || five_time || eight_time) begin
                if (init_s)         m_rest = 0;
                else if (save_s)    m_rest = (int'(p_rest_time) > 99) ? 99 : int'(p_rest_time);
                else if (red_s)     m_rest = 20;
                else if (green_s)   m_rest = 30;
                else if (yellow_s)  m_rest = 3;
                else if (five_time) m_rest = 5;
                else                m_rest = 8;
                m_el = 0;
            end else if (!pause_r && !dis) begin
                m_el++;
                if (m_el == TD) begin
                    m_el   = 0;
                    m_tick = 1;
                    if (m_rest > 0) m_rest--;
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_rest",  int'(rest_time), m_rest);
            chk("model_tens",  int'(tens),      m_tens);
            chk("model_ones",  int'(ones),      m_ones);
            chk("model_tick",  int'(tick),      int'(m_tick));
            chk("model_blank", int'(blank),     int'(m_blank));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ticks;
        cyc(2);
        chk("rst_rest", int'(rest_time), 0);
        chk("rst_tens", int'(tens), 0);
        chk("rst_ones", int'(ones), 0);
        chk("rst_tick", int'(tick), 0);
        chk("rst_blank", int'(blank), 1);
        rst = 0;
        cyc(2);

        // Red load held two cycles, then full countdown.
        red_s = 1;
        cyc(1); chk("red_c1", int'(rest_time), 20);
        cyc(1); chk("red_c2", int'(rest_time), 20);
        chk("red_tens", int'(tens), 2);
        chk("red_ones", int'(ones), 0);
        red_s = 0;
        cyc(3); chk("red_hold", int'(rest_time), 20);
        cyc(1); chk("red_19", int'(rest_time), 19);
        cyc(19 * TD); chk("red_zero", int'(rest_time), 0);
        ticks = 0;
        for (int i = 0; i < 2 * TD; i++) begin
            cyc(1);
            ticks += int'(tick);
        end
        chk("zero_ticks", ticks, 2);
        chk("zero_floor", int'(rest_time), 0);

        // Pause preserves the sub-second phase.
        green_s = 1; cyc(1); green_s = 0;
        cyc(6); chk("green_29", int'(rest_time), 29);
        pause_r = 1;
        ticks = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            ticks += int'(tick);
        end
        chk("pause_rest", int'(rest_time), 29);
        chk("pause_ticks", ticks, 0);
        pause_r = 0;
        cyc(1); chk("unpause_29", int'(rest_time), 29);
        cyc(1); chk("unpause_28", int'(rest_time), 28);

        // Priority and clamp.
        red_s = 1; yellow_s = 1; save_s = 1; p_rest_time = 7'd120;
        cyc(1); chk("clamp_99", int'(rest_time), 99);
        red_s = 0; yellow_s = 0; save_s = 0;
        cyc(1); chk("clamp_tens", int'(tens), 9);
        chk("clamp_ones", int'(ones), 9);
        init_s = 1; green_s = 1;
        cyc(1); chk("init_wins", int'(rest_time), 0);
        init_s = 0; green_s = 0;

        // Display disable freezes count; save resumes.
        red_s = 1; cyc(1); red_s = 0;
        dis = 1;
        cyc(1); chk("blank_on", int'(blank), 1);
        cyc(7); chk("dis_frozen", int'(rest_time), 20);
        dis = 0; save_s = 1; p_rest_time = 7'd17;
        cyc(1); chk("save_17", int'(rest_time), 17);
        save_s = 0;
        cyc(3); chk("save_hold", int'(rest_time), 17);
        cyc(1); chk("save_16", int'(rest_time), 16);

        // Manual sequence.
        five_time = 1; cyc(1); chk("five_load", int'(rest_time), 5); five_time = 0;
        cyc(5 * TD); chk("five_zero", int'(rest_time), 0);
        yellow_s = 1; cyc(1); chk("yel_load", int'(rest_time), 3); yellow_s = 0;
        cyc(3 * TD); chk("yel_zero", int'(rest_time), 0);
        eight_time = 1; cyc(1); chk("eight_load", int'(rest_time), 8); eight_time = 0;

        // Reset mid-count with a strobe high.
        red_s = 1; cyc(1); red_s = 0;
        cyc(8 * TD); chk("pre_rst_12", int'(rest_time), 12);
        rst = 1; red_s = 1;
        cyc(1);
        chk("mrst_rest", int'(rest_time), 0);
        chk("mrst_tens", int'(tens), 0);
        chk("mrst_ones", int'(ones), 0);
        chk("mrst_tick", int'(tick), 0);
        chk("mrst_blank", int'(blank), 1);
        rst = 0; red_s = 0;
        cyc(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
